// File: rtl/lc3_fetch_pkg.sv
// Shared types for the LC-3 fetch stage: prefetch entry layout, fetch FSM states
// and the default reset PC.
package lc3_fetch_pkg;

  localparam int LC3_ADDR_W = 16;
  localparam int LC3_DATA_W = 16;
  localparam logic [LC3_ADDR_W-1:0] LC3_RESET_PC = 16'h3000;

  // One prefetched word paired with the PC of the following instruction.
  typedef struct packed {
    logic [LC3_DATA_W-1:0] instr;
    logic [LC3_ADDR_W-1:0] npc;
  } fetch_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/lc3_fetch_buffer_if.sv
// Bus bundle between the fetch stage, instruction memory, the controller and
// the decode consumer; also carries the fetch FSM state for observation.
interface lc3_fetch_buffer_if
  import lc3_fetch_pkg::*;
#(
  parameter int ADDR_W = LC3_ADDR_W,
  parameter int DATA_W = LC3_DATA_W,
  parameter int DEPTH  = 4
);
  // Handshake: the head entry transfers on any rising edge where instr_valid
  // and instr_ready are both high; instr_valid never depends on instr_ready,
  // and instr_out/npc_out are meaningful only while instr_valid is high.
  logic                    enable_fetch;
  logic                    enable_updatePC;
  logic                    br_taken;
  logic [ADDR_W-1:0]       taddr;
  logic                    imem_rd;
  logic [ADDR_W-1:0]       imem_addr;
  logic [DATA_W-1:0]       imem_dout;
  logic [DATA_W-1:0]       instr_out;
  logic [ADDR_W-1:0]       npc_out;
  logic                    instr_valid;
  logic                    instr_ready;
  logic [$clog2(DEPTH):0]  fill_level;
  fetch_state_e            state;

  modport master (
    input  enable_fetch, enable_updatePC, br_taken, taddr, imem_dout, instr_ready,
    output imem_rd, imem_addr, instr_out, npc_out, instr_valid, fill_level, state
  );

  modport slave (
    output enable_fetch, enable_updatePC, br_taken, taddr, imem_dout, instr_ready,
    input  imem_rd, imem_addr, instr_out, npc_out, instr_valid, fill_level, state
  );

endinterface

// File: rtl/lc3_fetch_fifo.sv
// Synchronous FIFO of fetch entries; clear outranks push and pop.
module lc3_fetch_fifo
  import lc3_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/lc3_fetch_buffer.sv
// LC-3 fetch stage: owns the PC, issues one-cycle-latency imem reads under a
// credit limit and queues {instr, npc} pairs for the controller.
module lc3_fetch_buffer
  import lc3_fetch_pkg::*;
#(
  parameter int ADDR_W = LC3_ADDR_W,
  parameter int DATA_W = LC3_DATA_W,
  parameter int DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = LC3_RESET_PC
) (
  input  logic clock,
  input  logic reset,
  lc3_fetch_buffer_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] tag_q;
  logic              inflight_q;
  logic              issue;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     count;
  logic [CW:0]       credit_used;
  logic [DATA_W-1:0] rd_data;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;
  fetch_entry_t      last_q;

  assign rd_data          = bus.imem_dout;
  assign push_entry.instr = rd_data;
  assign push_entry.npc   = tag_q + ADDR_W'(1);
  // The in-flight read holds a slot, so a returning word always finds room.
  assign credit_used      = {1'b0, count} + (CW + 1)'(inflight_q);
  assign push             = inflight_q && !fifo_full;
  assign pop              = bus.instr_valid && bus.instr_ready;

  lc3_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clock),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .clear (bus.br_taken),
    .din   (push_entry),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      RUN: begin
        issue = !reset && !bus.br_taken && bus.enable_fetch && bus.enable_updatePC &&
                (credit_used < (CW + 1)'(DEPTH));
        if (bus.br_taken) state_d = FLUSH;
      end
      FLUSH: state_d = bus.br_taken ? FLUSH : RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      last_q     <= '0;
    end else begin
      state_q <= state_d;
      if (!fifo_empty) last_q <= head;
      // A redirect drops the outstanding read: the FIFO clear discards its data.
      if (bus.br_taken) begin
        pc_q       <= bus.taddr;
        inflight_q <= 1'b0;
      end else if (issue) begin
        pc_q       <= pc_q + ADDR_W'(1);
        tag_q      <= pc_q;
        inflight_q <= 1'b1;
      end else begin
        inflight_q <= 1'b0;
      end
    end
  end

  assign bus.imem_rd     = issue;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = !fifo_empty;
  assign bus.instr_out   = fifo_empty ? last_q.instr : head.instr;
  assign bus.npc_out     = fifo_empty ? last_q.npc : head.npc;
  assign bus.fill_level  = count;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_lc3_fetch_buffer.sv
// Directed bench for lc3_fetch_buffer: scripted cycles drive the controls, a
// queue of expected {instr, npc} pairs is consumed by an independent monitor.
module tb_lc3_fetch_buffer;
  import lc3_fetch_pkg::*;

  logic clk;
  logic reset;
  logic [15:0] mem_q;
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;
  int n_cmp = 0;
  int n_bad = 0;

  lc3_fetch_buffer_if #(.ADDR_W(16), .DATA_W(16), .DEPTH(4)) bus ();

  lc3_fetch_buffer #(.ADDR_W(16), .DATA_W(16), .DEPTH(4), .RESET_PC(16'h3000)) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  // instruction memory: data = addr ^ A5A5, one cycle after the read strobe
  always @(posedge clk) begin
    if (bus.imem_rd) mem_q <= bus.imem_addr ^ 16'hA5A5;
  end
  assign bus.imem_dout = mem_q;

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [15:0] a);
    logic [15:0] npc;
    npc = a + 16'd1;
    exp_q.push_back({a ^ 16'hA5A5, npc});
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset && bus.instr_valid && bus.instr_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pop: got %h required none", {bus.instr_out, bus.npc_out});
      end else begin
        mon_e = exp_q.pop_front();
        check("pop", {bus.instr_out, bus.npc_out}, mon_e);
      end
    end
  end

  initial begin
    reset               = 1'b1;
    bus.enable_fetch    = 1'b0;
    bus.enable_updatePC = 1'b0;
    bus.br_taken        = 1'b0;
    bus.taddr           = '0;
    bus.instr_ready     = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst_fill", 32'(bus.fill_level), 0);
    check("rst_valid", 32'(bus.instr_valid), 0);
    check("rst_rd", 32'(bus.imem_rd), 0);
    check("rst_addr", 32'(bus.imem_addr), 32'h3000);
    check("rst_instr", 32'(bus.instr_out), 0);
    check("rst_npc", 32'(bus.npc_out), 0);

    // fill with no consumer
    next_cycle();
    reset = 1'b0;
    bus.enable_fetch    = 1'b1;
    bus.enable_updatePC = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("fill_rd", 32'(bus.imem_rd), 1);
      check("fill_addr", 32'(bus.imem_addr), 32'h3000 + i);
      push_exp(16'(32'h3000 + i));
      next_cycle();
    end
    @(negedge clk);
    check("credit_rd", 32'(bus.imem_rd), 0);
    next_cycle();
    @(negedge clk);
    check("full_rd", 32'(bus.imem_rd), 0);
    check("full_fill", 32'(bus.fill_level), 4);
    check("full_valid", 32'(bus.instr_valid), 1);
    check("full_instr", 32'(bus.instr_out), 32'h95A5);
    check("full_npc", 32'(bus.npc_out), 32'h3001);

    // continuous consumer
    next_cycle();
    bus.instr_ready = 1'b1;
    @(negedge clk);
    check("drain_rd0", 32'(bus.imem_rd), 0);
    check("drain_fill0", 32'(bus.fill_level), 4);
    next_cycle();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("stream_rd", 32'(bus.imem_rd), 1);
      check("stream_addr", 32'(bus.imem_addr), 32'h3004 + k);
      check("stream_fill", 32'(bus.fill_level), (k == 0) ? 3 : 2);
      push_exp(16'(32'h3004 + k));
      next_cycle();
    end

    // reset, then redirect with the 3002 read outstanding
    reset = 1'b1;
    bus.instr_ready = 1'b0;
    exp_q.delete();
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("pre_br_addr", 32'(bus.imem_addr), 32'h3000 + i);
      next_cycle();
    end
    bus.br_taken = 1'b1;
    bus.taddr    = 16'h4000;
    @(negedge clk);
    check("br_rd", 32'(bus.imem_rd), 0);
    check("br_fill", 32'(bus.fill_level), 2);
    next_cycle();
    bus.br_taken    = 1'b0;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    check("flush_valid", 32'(bus.instr_valid), 0);
    check("flush_fill", 32'(bus.fill_level), 0);
    check("flush_rd", 32'(bus.imem_rd), 0);
    check("flush_addr", 32'(bus.imem_addr), 32'h4000);
    check("flush_state", 32'(bus.state), 32'(FLUSH));
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("tgt_rd", 32'(bus.imem_rd), 1);
      check("tgt_addr", 32'(bus.imem_addr), 32'h4000 + k);
      push_exp(16'(32'h4000 + k));
      if (k == 2) begin
        check("tgt_valid", 32'(bus.instr_valid), 1);
        check("tgt_npc", 32'(bus.npc_out), 32'h4001);
        check("tgt_instr", 32'(bus.instr_out), 32'hE5A5);
      end
      next_cycle();
    end

    // redirect to FFFF and fetch two words across the wrap
    bus.br_taken    = 1'b1;
    bus.taddr       = 16'hFFFF;
    bus.instr_ready = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("br2_rd", 32'(bus.imem_rd), 0);
    next_cycle();
    bus.br_taken = 1'b0;
    @(negedge clk);
    check("flush2_rd", 32'(bus.imem_rd), 0);
    check("flush2_addr", 32'(bus.imem_addr), 32'hFFFF);
    check("flush2_valid", 32'(bus.instr_valid), 0);
    next_cycle();
    @(negedge clk);
    check("wrap_addr0", 32'(bus.imem_addr), 32'hFFFF);
    check("wrap_rd0", 32'(bus.imem_rd), 1);
    push_exp(16'hFFFF);
    next_cycle();
    @(negedge clk);
    check("wrap_addr1", 32'(bus.imem_addr), 32'h0000);
    check("wrap_rd1", 32'(bus.imem_rd), 1);
    push_exp(16'h0000);
    next_cycle();
    bus.enable_fetch = 1'b0;
    bus.instr_ready  = 1'b1;
    @(negedge clk);
    check("wrap_stop_rd", 32'(bus.imem_rd), 0);
    check("wrap_npc0", 32'(bus.npc_out), 32'h0000);
    check("wrap_instr0", 32'(bus.instr_out), 32'h5A5A);
    next_cycle();
    @(negedge clk);
    check("wrap_npc1", 32'(bus.npc_out), 32'h0001);
    next_cycle();
    @(negedge clk);
    check("hold_valid", 32'(bus.instr_valid), 0);
    check("hold_instr", 32'(bus.instr_out), 32'hA5A5);
    check("hold_npc", 32'(bus.npc_out), 32'h0001);
    next_cycle();

    // enable_updatePC low for three cycles mid-stream
    bus.enable_fetch = 1'b1;
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      check("pre_stall_addr", 32'(bus.imem_addr), 32'(k));
      check("pre_stall_rd", 32'(bus.imem_rd), 1);
      push_exp(16'(k));
      next_cycle();
    end
    bus.enable_updatePC = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("stall_rd", 32'(bus.imem_rd), 0);
      check("stall_addr", 32'(bus.imem_addr), 32'h0003);
      if (j == 1) begin
        check("stall_valid", 32'(bus.instr_valid), 1);
        check("stall_npc", 32'(bus.npc_out), 32'h0003);
      end
      next_cycle();
    end
    bus.enable_updatePC = 1'b1;
    @(negedge clk);
    check("resume_rd", 32'(bus.imem_rd), 1);
    check("resume_addr", 32'(bus.imem_addr), 32'h0003);
    push_exp(16'h0003);
    next_cycle();
    bus.enable_fetch = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    check("drain_left", 32'(exp_q.size()), 0);
    check("drain_valid", 32'(bus.instr_valid), 0);
    next_cycle();

    // reset with three entries queued and a read outstanding
    bus.enable_fetch = 1'b1;
    bus.instr_ready  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("refill_addr", 32'(bus.imem_addr), 32'h0004 + i);
      next_cycle();
    end
    reset = 1'b1;
    @(negedge clk);
    check("prerst_fill", 32'(bus.fill_level), 3);
    check("prerst_rd", 32'(bus.imem_rd), 0);
    next_cycle();
    reset = 1'b0;
    bus.enable_fetch = 1'b0;
    @(negedge clk);
    check("midrst_fill", 32'(bus.fill_level), 0);
    check("midrst_valid", 32'(bus.instr_valid), 0);
    check("midrst_addr", 32'(bus.imem_addr), 32'h3000);
    check("midrst_npc", 32'(bus.npc_out), 0);
    next_cycle();
    @(negedge clk);
    check("stale_fill", 32'(bus.fill_level), 0);
    check("stale_valid", 32'(bus.instr_valid), 0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lc3_fetch_buffer.md
Name: lc3_fetch_buffer

Overview:
Instruction fetch stage that sits directly ahead of the controller/decode path. It owns the PC and issues reads to instruction memory. Returned instructions, each paired with its NPC, are queued in a small prefetch FIFO. The FIFO presents the instruction that becomes the controller's IR input and honours the controller's enable_fetch, enable_updatePC and branch redirect.

Parameters:
ADDR_W, 16, PC/address width
DATA_W, 16, instruction width
DEPTH, 4, prefetch FIFO entries (power of 2, >=2)
RESET_PC, 16'h3000, PC value after reset

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
enable_fetch  in  1  controller permits new memory reads
enable_updatePC  in  1  controller permits PC advance
br_taken  in  1  redirect request, valid for one cycle
taddr  in  ADDR_W  redirect target
imem_rd  out  1  instruction memory read strobe
imem_addr  out  ADDR_W  read address (current PC)
imem_dout  in  DATA_W  read data, 1 cycle after imem_rd
instr_out  out  DATA_W  head-of-FIFO instruction
npc_out  out  ADDR_W  head-of-FIFO NPC (fetch PC + 1)
instr_valid  out  1  FIFO not empty
instr_ready  in  1  downstream accepts head this cycle
fill_level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (synchronous, active-high):
  - pc = RESET_PC; FIFO empty; fill_level = 0.
  - imem_rd = 0; instr_valid = 0; instr_out = 0; npc_out = 0.
  - In-flight flag cleared; FSM = RUN.
- Issue rule:
  - imem_rd = enable_fetch && enable_updatePC && state==RUN && (fill_level + inflight) < DEPTH.
  - Issue is combinational; imem_addr = pc at all times.
- On issue: pc <= pc + 1 (mod 2^ADDR_W; 16'hFFFF wraps to 0). inflight <= 1, tagged with the issued pc.
- Response:
  - Data arrives on the cycle after issue.
  - If inflight and not killed, push {imem_dout, tag_pc+1}.
  - Fetch-to-instr_valid latency is 2 cycles from issue when the FIFO was empty.
- Pop: on instr_valid && instr_ready the head advances. Simultaneous push and pop leaves fill_level unchanged.
- Full: a push into a full FIFO cannot occur, because the credit rule counts the in-flight read.
- Empty: instr_valid = 0. instr_out and npc_out hold their last values; they must not be consumed.
- FSM states:
  - RUN: normal issue. On br_taken go to FLUSH.
  - FLUSH: one cycle with no issue. It absorbs the killed in-flight response, then returns to RUN.
- br_taken, in the cycle it is seen:
  - pc <= taddr.
  - FIFO cleared (fill_level <= 0).
  - Any in-flight read is marked killed; its data is dropped next cycle.
  - A same-cycle issue is suppressed.
- Priority: reset > br_taken > push/pop > PC increment. A pop in the same cycle as br_taken is still a handshake for the downstream side, but the FIFO ends empty.
- enable_updatePC low: no issue and pc holds. Existing FIFO contents and the in-flight response still complete normally.
- br_taken while in FLUSH: redirect again to the new taddr and stay in FLUSH one more cycle.
- Reset mid-operation: all state returns to reset values on the next edge; an in-flight response is ignored.

Decomposition:
- Shared package lc3_fetch_pkg holds:
  - fetch_entry_t struct {instr[DATA_W], npc[ADDR_W]}
  - fetch_state_e {RUN, FLUSH}
  - RESET_PC default constant
- One sub-module, lc3_fetch_fifo:
  - Parameterised sync FIFO of fetch_entry_t.
  - Ports: push, pop, clear, full, empty, count.
  - clear has priority over push and pop.

Test Plan:
- Reset, then enable_fetch=enable_updatePC=1, instr_ready=0, memory returns addr^16'hA5A5:
  - imem_addr steps 3000..3003, then imem_rd drops.
  - fill_level=4; head instr=16'h95A5, npc=16'h3001.
- Same fill, then instr_ready=1 continuous:
  - One pop per cycle; sustained imem_rd=1.
  - Instructions in address order; fill_level steady.
- br_taken with taddr=16'h4000 while an in-flight read to 16'h3002 is pending:
  - FIFO empty next cycle; the 16'h3002 data is never presented.
  - Next imem_addr=16'h4000 after the one FLUSH cycle.
  - First valid npc_out=16'h4001.
- Set pc to 16'hFFFF via br_taken and fetch two words:
  - Addresses FFFF then 0000; npc_out 0000 then 0001.
- enable_updatePC=0 for 3 cycles mid-stream:
  - No imem_rd; pc holds.
  - Already-issued word is still pushed; resumes at the next address.
- Assert reset with fill_level=3 and a read in flight:
  - Next cycle fill_level=0, instr_valid=0, imem_addr=16'h3000.
  - The stale response is not pushed.
